bounded_updown_counter: RTL and testbench

Parametrised next-generation up/down counter with runtime-programmable lower/upper bounds, variable step size and a selectable wrap or saturate policy. It adds a clock enable, a registered terminal-count pulse, sticky overflow/underflow flags and bound-configuration error detection. It is the general counting primitive for timers, address generators and credit counters across the design.

---
 rtl/counter_pkg.sv | 58 +++++
 rtl/bounded_step_calc.sv | 59 +++++
 rtl/bounded_updown_counter.sv | 114 +++++++++++
 tb/tb_bounded_updown_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and arithmetic helpers for the bounded up/down counter family.
//
// All helpers work on a fixed (CNT_MAX_W+1)-bit intermediate so that
// count + step and lo_bound + step can never wrap silently, whatever the
// instantiated counter width (up to CNT_MAX_W bits). Callers zero-extend
// their operands into cnt_wide_t and truncate the result back to WIDTH.
// -----------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic {CNT_DOWN = 1'b0, CNT_UP   = 1'b1} cnt_dir_e;
  typedef enum logic {POL_SAT  = 1'b0, POL_WRAP = 1'b1} cnt_pol_e;

  // Widest counter supported by the helpers; one extra bit holds the carry.
  localparam int CNT_MAX_W = 64;
  typedef logic [CNT_MAX_W:0] cnt_wide_t;

  // Clamp v into the inclusive range [lo, hi].
  function automatic cnt_wide_t clamp_wide(input cnt_wide_t v,
                                           input cnt_wide_t lo,
                                           input cnt_wide_t hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // Stepping up would pass (or already sits beyond) the upper bound.
  function automatic logic up_event(input cnt_wide_t cnt,
                                    input cnt_wide_t step,
                                    input cnt_wide_t hi);
    return (cnt + step) > hi;
  endfunction

  // Stepping down would pass (or already sits below) the lower bound.
  function automatic logic dn_event(input cnt_wide_t cnt,
                                    input cnt_wide_t step,
                                    input cnt_wide_t lo);
    return cnt < (lo + step);
  endfunction

  // Next count given whether a boundary event fires. Without an event the
  // down path cannot underflow because cnt >= lo + step is guaranteed.
  function automatic cnt_wide_t step_next(input cnt_wide_t cnt,
                                          input cnt_wide_t step,
                                          input cnt_wide_t lo,
                                          input cnt_wide_t hi,
                                          input cnt_dir_e  dir,
                                          input cnt_pol_e  pol,
                                          input logic      evt);
    if (evt) begin
      if (dir == CNT_UP) return (pol == POL_WRAP) ? lo : hi;
      else               return (pol == POL_WRAP) ? hi : lo;
    end
    return (dir == CNT_UP) ? (cnt + step) : (cnt - step);
  endfunction

endpackage

// File: rtl/bounded_step_calc.sv
// -----------------------------------------------------------------------------
// bounded_step_calc
// Purely combinational next-state calculator for one enabled counting step.
//
// Ports:
//   count      in   current count
//   step       in   step magnitude (zero-extended)
//   lo_bound   in   inclusive lower bound
//   hi_bound   in   inclusive upper bound
//   mode       in   1 = up, 0 = down
//   wrap       in   1 = wrap to opposite bound, 0 = saturate
//   next_count out  count after an enabled step
//   up_evt     out  up boundary event
//   dn_evt     out  down boundary event
//
// Enable, load and configuration-error gating are applied by the caller.
// A zero step never raises an event: the count simply holds.
// -----------------------------------------------------------------------------
module bounded_step_calc
  import counter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 8
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo_bound,
  input  logic [WIDTH-1:0]  hi_bound,
  input  logic              mode,
  input  logic              wrap,
  output logic [WIDTH-1:0]  next_count,
  output logic              up_evt,
  output logic              dn_evt
);

  cnt_wide_t count_w;
  cnt_wide_t step_w;
  cnt_wide_t lo_w;
  cnt_wide_t hi_w;
  cnt_wide_t next_w;
  cnt_dir_e  dir;
  cnt_pol_e  pol;
  logic      step_nz;

  assign count_w = cnt_wide_t'(count);
  assign step_w  = cnt_wide_t'(step);
  assign lo_w    = cnt_wide_t'(lo_bound);
  assign hi_w    = cnt_wide_t'(hi_bound);
  assign dir     = cnt_dir_e'(mode);
  assign pol     = cnt_pol_e'(wrap);
  assign step_nz = |step;

  assign up_evt = (dir == CNT_UP)   && step_nz && up_event(count_w, step_w, hi_w);
  assign dn_evt = (dir == CNT_DOWN) && step_nz && dn_event(count_w, step_w, lo_w);

  assign next_w     = step_next(count_w, step_w, lo_w, hi_w, dir, pol, up_evt | dn_evt);
  assign next_count = WIDTH'(next_w);

endmodule

// File: rtl/bounded_updown_counter.sv
// -----------------------------------------------------------------------------
// bounded_updown_counter
// Up/down counter with runtime bounds, variable step and wrap/saturate policy.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   en         in   count enable
//   mode       in   1 = up, 0 = down
//   load       in   synchronous load strobe (wins over en)
//   load_val   in   value to load, clamped into [lo_bound, hi_bound]
//   step       in   step magnitude, zero-extended
//   lo_bound   in   inclusive lower bound
//   hi_bound   in   inclusive upper bound
//   wrap       in   1 = wrap to opposite bound, 0 = saturate at reached bound
//   clr_flags  in   clears both sticky flags (a coincident set wins)
//   count      out  current count, registered
//   tc         out  one-cycle terminal-count pulse after a boundary event
//   ovf_sticky out  set by an up boundary event
//   udf_sticky out  set by a down boundary event
//   bound_err  out  registered lo_bound > hi_bound
//
// Per-cycle precedence: rst > bound error > load > en.
// -----------------------------------------------------------------------------
module bounded_updown_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               STEP_W    = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo_bound,
  input  logic [WIDTH-1:0]  hi_bound,
  input  logic              wrap,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf_sticky,
  output logic              udf_sticky,
  output logic              bound_err
);

  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_clamped;
  logic             up_evt;
  logic             dn_evt;
  logic             cfg_err;

  // The live condition gates this cycle's update; bound_err is its registered copy.
  assign cfg_err      = lo_bound > hi_bound;
  assign load_clamped = WIDTH'(clamp_wide(cnt_wide_t'(load_val),
                                          cnt_wide_t'(lo_bound),
                                          cnt_wide_t'(hi_bound)));

  bounded_step_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step_calc (
    .count      (count),
    .step       (step),
    .lo_bound   (lo_bound),
    .hi_bound   (hi_bound),
    .mode       (mode),
    .wrap       (wrap),
    .next_count (next_count),
    .up_evt     (up_evt),
    .dn_evt     (dn_evt)
  );

  // NOTE: non-blocking assignments throughout, so every register samples the
  // pre-edge values and later statements may override earlier ones (set wins
  // over clear below) without ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= RESET_VAL;
      tc         <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
      bound_err  <= 1'b0;
    end else begin
      bound_err <= cfg_err;
      tc        <= 1'b0;

      if (clr_flags) begin
        ovf_sticky <= 1'b0;
        udf_sticky <= 1'b0;
      end

      if (cfg_err) begin
        // Misconfigured bounds: freeze everything until they are fixed.
      end else if (load) begin
        count <= load_clamped;
      end else if (en) begin
        count <= next_count;
        if (up_evt) begin
          tc         <= 1'b1;
          ovf_sticky <= 1'b1;
        end
        if (dn_evt) begin
          tc         <= 1'b1;
          udf_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bounded_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bounded_updown_counter
// Self-checking bench: a table of per-cycle vectors with hand-derived expected
// outputs, fed through a scoreboard queue, plus a hand-written asynchronous
// reset sequence.
// -----------------------------------------------------------------------------
module tb_bounded_updown_counter;

  localparam int WIDTH  = 32;
  localparam int STEP_W = 8;

  logic              clk;
  logic              rst;
  logic              en;
  logic              mode;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  lo_bound;
  logic [WIDTH-1:0]  hi_bound;
  logic              wrap;
  logic              clr_flags;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              ovf_sticky;
  logic              udf_sticky;
  logic              bound_err;

  bounded_updown_counter #(
    .WIDTH     (WIDTH),
    .STEP_W    (STEP_W),
    .RESET_VAL ('0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .load       (load),
    .load_val   (load_val),
    .step       (step),
    .lo_bound   (lo_bound),
    .hi_bound   (hi_bound),
    .wrap       (wrap),
    .clr_flags  (clr_flags),
    .count      (count),
    .tc         (tc),
    .ovf_sticky (ovf_sticky),
    .udf_sticky (udf_sticky),
    .bound_err  (bound_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic              en;
    logic              mode;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic              wrap;
    logic              clr;
    logic [WIDTH-1:0]  e_count;
    logic              e_tc;
    logic              e_ovf;
    logic              e_udf;
    logic              e_berr;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name,
                              input logic en_i, input logic mode_i, input logic load_i,
                              input logic [WIDTH-1:0] lv, input logic [STEP_W-1:0] st,
                              input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi,
                              input logic wr, input logic clr,
                              input logic [WIDTH-1:0] ec, input logic et,
                              input logic eo, input logic eu, input logic eb);
    vec_t v;
    v.name = name; v.en = en_i; v.mode = mode_i; v.load = load_i; v.load_val = lv;
    v.step = st; v.lo = lo; v.hi = hi; v.wrap = wr; v.clr = clr;
    v.e_count = ec; v.e_tc = et; v.e_ovf = eo; v.e_udf = eu; v.e_berr = eb;
    return v;
  endfunction

  task automatic compare_front();
    vec_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({e.name, "/count"}, 64'(count),      64'(e.e_count));
      check({e.name, "/tc"},    64'(tc),         64'(e.e_tc));
      check({e.name, "/ovf"},   64'(ovf_sticky), 64'(e.e_ovf));
      check({e.name, "/udf"},   64'(udf_sticky), 64'(e.e_udf));
      check({e.name, "/berr"},  64'(bound_err),  64'(e.e_berr));
    end
  endtask

  task automatic apply_vec(input vec_t v);
    en = v.en; mode = v.mode; load = v.load; load_val = v.load_val;
    step = v.step; lo_bound = v.lo; hi_bound = v.hi; wrap = v.wrap; clr_flags = v.clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  // Watchdog: the stimulus is a fixed number of cycles, this only guards hangs.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Table columns: name, en, mode, load, load_val, step, lo, hi, wrap, clr,
    //                exp count, exp tc, exp ovf, exp udf, exp bound_err
    // Full-range wrap at 2^32.
    vecs.push_back(mk("t1_load",      0,1,1,32'hFFFF_FFFE,1, 0,32'hFFFF_FFFF,1,0, 32'hFFFF_FFFE,0,0,0,0));
    vecs.push_back(mk("t1_en1",       1,1,0,0,            1, 0,32'hFFFF_FFFF,1,0, 32'hFFFF_FFFF,0,0,0,0));
    vecs.push_back(mk("t1_en2_wrap",  1,1,0,0,            1, 0,32'hFFFF_FFFF,1,0, 32'h0,        1,1,0,0));
    // Saturate up, repeated tc, then a normal step down and a plain clear.
    vecs.push_back(mk("t2_load",      0,1,1,18,3,10,20,0,0, 18,0,1,0,0));
    vecs.push_back(mk("t2_sat1",      1,1,0,0, 3,10,20,0,0, 20,1,1,0,0));
    vecs.push_back(mk("t2_sat2",      1,1,0,0, 3,10,20,0,0, 20,1,1,0,0));
    vecs.push_back(mk("t2_sat3",      1,1,0,0, 3,10,20,0,0, 20,1,1,0,0));
    vecs.push_back(mk("t2_down",      1,0,0,0, 3,10,20,0,0, 17,0,1,0,0));
    vecs.push_back(mk("t2_clr",       0,0,0,0, 3,10,20,0,1, 17,0,0,0,0));
    // Down wrap, clear, then clear coincident with a new event.
    vecs.push_back(mk("t3_load",      0,0,1,12,4,10,20,1,0, 12,0,0,0,0));
    vecs.push_back(mk("t3_dn_wrap",   1,0,0,0, 4,10,20,1,0, 20,1,0,1,0));
    vecs.push_back(mk("t3_clr",       0,0,0,0, 4,10,20,1,1, 20,0,0,0,0));
    vecs.push_back(mk("t3_clr_vs_set",1,0,0,0,15,10,20,1,1, 20,1,0,1,0));
    // Load clamping, load beats en.
    vecs.push_back(mk("t4_load_lo",   1,1,1,5, 4,10,20,1,0, 10,0,0,1,0));
    vecs.push_back(mk("t4_load_hi",   0,1,1,99,4,10,20,1,0, 20,0,0,1,0));
    // Bound configuration error freezes the counter.
    vecs.push_back(mk("t5_err_en",    1,0,0,0, 4,30,20,1,0, 20,0,0,1,1));
    vecs.push_back(mk("t5_err_load",  0,0,1,5, 4,30,20,1,0, 20,0,0,1,1));
    vecs.push_back(mk("t5_err_up",    1,1,0,0, 4,30,20,1,0, 20,0,0,1,1));
    vecs.push_back(mk("t5_restore",   0,1,0,0, 4,10,20,1,0, 20,0,0,1,0));
    // Zero step at a bound, then count outside bounds after a hi change.
    vecs.push_back(mk("step0_at_hi",  1,1,0,0, 0,10,20,0,0, 20,0,0,1,0));
    vecs.push_back(mk("oob_dn_normal",1,0,0,0, 1,10,15,0,0, 19,0,0,1,0));
    vecs.push_back(mk("oob_up_event", 1,1,0,0, 1,10,15,0,0, 15,1,1,1,0));
    // Lead-in for the asynchronous reset sequence.
    vecs.push_back(mk("t6_load",      0,1,1,12,3,10,20,0,0, 12,0,1,1,0));
    vecs.push_back(mk("t6_up",        1,1,0,0, 3,10,20,0,0, 15,0,1,1,0));

    // Reset state, checked while rst is held.
    rst = 1'b1; en = 1'b0; mode = 1'b1; load = 1'b0; load_val = '0; step = 8'd1;
    lo_bound = '0; hi_bound = '1; wrap = 1'b1; clr_flags = 1'b0;
    #2;
    check("reset/count", 64'(count),      64'd0);
    check("reset/tc",    64'(tc),         64'd0);
    check("reset/ovf",   64'(ovf_sticky), 64'd0);
    check("reset/udf",   64'(udf_sticky), 64'd0);
    check("reset/berr",  64'(bound_err),  64'd0);
    #10;
    rst = 1'b0;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Asynchronous reset mid-count: en stays high, counting up by 3 from 15.
    #3;
    rst = 1'b1;
    #1;
    check("arst/count", 64'(count),      64'd0);
    check("arst/tc",    64'(tc),         64'd0);
    check("arst/ovf",   64'(ovf_sticky), 64'd0);
    check("arst/udf",   64'(udf_sticky), 64'd0);
    check("arst/berr",  64'(bound_err),  64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("arst_resume1/count", 64'(count), 64'd3);
    check("arst_resume1/tc",    64'(tc),    64'd0);
    @(posedge clk);
    #1;
    check("arst_resume2/count", 64'(count), 64'd6);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
